// File: rtl/qarma_shuffle_stage.sv
// QARMA-128 pre-diffusion stage: XOR with the round tweakey, tau / tau^-1 cell shuffle,
// and a 2-entry skid buffer in front of MixColumns.
module qarma_shuffle_stage #(
  parameter int n     = 128,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     in_state,
  input  logic [n-1:0]     in_tk,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n-1:0]     out_state,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy
);

  localparam int M = n >> 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [3:0] TAU     [16] = '{4'd0, 4'd11, 4'd6, 4'd13, 4'd10, 4'd1, 4'd12, 4'd7,
                                          4'd5, 4'd14, 4'd3, 4'd8, 4'd15, 4'd4, 4'd9, 4'd2};
  localparam logic [3:0] TAU_INV [16] = '{4'd0, 4'd5, 4'd15, 4'd10, 4'd13, 4'd8, 4'd2, 4'd7,
                                          4'd11, 4'd14, 4'd4, 4'd1, 4'd6, 4'd3, 4'd9, 4'd12};

  // Output cell i takes source cell P[i]; cell 0 is the most significant cell.
  function automatic logic [n-1:0] shuffle(input logic [n-1:0] x, input logic inv);
    logic [n-1:0] r;
    int           src;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      src = inv ? int'(TAU_INV[i]) : int'(TAU[i]);
      r[n-1-i*M -: M] = x[n-1-src*M -: M];
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [n-1:0]     main_state_q, main_state_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic [n-1:0]     skid_state_q, skid_state_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic             send;
  logic [n-1:0]     shuf;

  assign accept = in_valid & in_ready_q;
  assign send   = out_valid_q & out_ready;
  assign shuf   = shuffle(in_state ^ in_tk, in_inv);

  always_comb begin
    state_d      = state_q;
    main_state_d = main_state_q;
    main_tag_d   = main_tag_q;
    skid_state_d = skid_state_q;
    skid_tag_d   = skid_tag_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          main_state_d = shuf;
          main_tag_d   = in_tag;
        end
      end
      ONE: begin
        if (accept && send) begin
          main_state_d = shuf;
          main_tag_d   = in_tag;
        end else if (accept) begin
          state_d      = TWO;
          skid_state_d = shuf;
          skid_tag_d   = in_tag;
        end else if (send) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (send) begin
          state_d      = ONE;
          main_state_d = skid_state_q;
          main_tag_d   = skid_tag_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over any same-cycle accept or send; register data is left as don't-care.
    if (flush) begin
      state_d = EMPTY;
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_state_q <= '0;
      main_tag_q   <= '0;
      skid_state_q <= '0;
      skid_tag_q   <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      main_state_q <= main_state_d;
      main_tag_q   <= main_tag_d;
      skid_state_q <= skid_state_d;
      skid_tag_q   <= skid_tag_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = main_state_q;
  assign out_tag   = main_tag_q;
  assign occupancy = state_q;

endmodule
